seg7_frame_serializer: RTL
==========================

# seg7_frame_serializer

Parametrised shift-register driver for multi-digit 7-segment displays. Accepts a packed frame of segment patterns for `NUM_DIGITS` digits and shifts it out on a serial data/clock/latch interface with a programmable serial-clock divider. Adds a start/busy/done handshake and an optional self-refresh mode. It sits between the clock's BCD-to-7-segment stage and the external shift-register chain.

## Interface
- `NUM_DIGITS`, default 6: digits per frame, ≥1.
- `SEG_WIDTH`, default 8: bits per digit (7 segments plus DP), ≥1.
- `CLK_DIV`, default 4: system cycles per serial-clock half-period, ≥1.
- `MSB_FIRST`, default 1: 1 shifts frame bit B-1 first; 0 shifts bit 0 first.
- `REFRESH_CYCLES`, default 1024: idle gap before an automatic frame, ≥1. Used only with the macro below.
- `i_clk` in 1: system clock.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_start` in 1: frame request, sampled in IDLE only.
- `i_data` in `NUM_DIGITS*SEG_WIDTH`: packed frame. Digit 0 is in the LSBs.
- `o_busy` out 1: frame in progress.
- `o_done` out 1: one-cycle pulse when a frame completes.
- `o_serial_data` out 1: serial data.
- `o_serial_clk` out 1: serial shift clock. Data is valid on the rising edge.
- `o_serial_latch` out 1: latch pulse to the shift-register chain.

## Operation
- The frame length is B = `NUM_DIGITS*SEG_WIDTH`.
- The bit counter is `$clog2(B+1)` bits wide. The divider counter is `$clog2(CLK_DIV+1)` bits wide.
- States:
  - IDLE: wait for a request.
  - SHIFT_LO: `o_serial_clk`=0. Current bit driven on `o_serial_data`. Lasts `CLK_DIV` cycles.
  - SHIFT_HI: `o_serial_clk`=1. Same data held. Lasts `CLK_DIV` cycles.
  - LATCH: `o_serial_latch`=1, clk=0, data=0. Lasts `CLK_DIV` cycles.
- Transitions:
  - IDLE→SHIFT_LO when `i_start`=1. `i_data` is captured into the shift register on that edge.
  - SHIFT_LO→SHIFT_HI after `CLK_DIV` cycles.
  - SHIFT_HI→SHIFT_LO after `CLK_DIV` cycles if bits remain. The shift register advances one bit on this transition.
  - SHIFT_HI→LATCH after the last bit.
  - LATCH→IDLE after `CLK_DIV` cycles. `o_done`=1 for the first IDLE cycle.
- `o_busy`=1 in SHIFT_LO, SHIFT_HI and LATCH. Otherwise 0.
- `i_data` changes during a frame are ignored. The captured copy is shifted.
- `i_start` outside IDLE is ignored and is not queued.
- `i_start` held high produces back-to-back frames. A new frame is accepted in the same cycle `o_done` pulses.
- All outputs are registered.

## Timing
- Reset value of every output is 0. The state returns to IDLE.
- Reset mid-frame aborts the frame immediately. No `o_done` is issued and no latch pulse is issued.
- `i_start` high in cycle 0 gives the following:
  - `o_busy` is high from cycle 1.
  - Bit k occupies cycles 1+2k·`CLK_DIV` through 2(k+1)·`CLK_DIV`.
  - Latch occupies cycles 2B·`CLK_DIV`+1 through 2B·`CLK_DIV`+`CLK_DIV`.
  - `o_done` is high in cycle 2B·`CLK_DIV`+`CLK_DIV`+1.
- Frame period with continuous `i_start` is (2B+1)·`CLK_DIV`+1 cycles.
- With `CLK_DIV`=1, `o_serial_clk` runs at `i_clk`/2.

## Configuration
- Macro: `SEG7_SER_AUTO_REFRESH_EN`.
- Defined:
  - An idle counter starts at the `o_done` cycle.
  - After `REFRESH_CYCLES` IDLE cycles, a frame starts exactly as if `i_start` were asserted.
  - `i_start` in IDLE starts a frame immediately and clears the idle counter.
  - If `i_start` and refresh expiry coincide, exactly one frame starts.
  - After reset, the first automatic frame occurs `REFRESH_CYCLES` cycles after reset deassertion.
- Undefined: frames start only on `i_start`. No idle counter is built.

## Structure
- A shared package `display_pkg` holds:
  - state encoding localparams (IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3);
  - segment bit-order constants (a..g, dp positions).
- One sub-module, `serial_tick_gen`:
  - loadable down-counter of `CLK_DIV` cycles;
  - emits a one-cycle `tick` on expiry;
  - reloads on state change.
- The FSM, shift register and bit counter live in the top module.

## Test plan
- Shift a 2-digit frame: `NUM_DIGITS`=2, `SEG_WIDTH`=8, `CLK_DIV`=2, `MSB_FIRST`=1, `i_data`=16'hA5C3, `i_start` pulsed in cycle 0.
  - 16 rising edges of `o_serial_clk`, sampling 1010_0101_1100_0011.
  - Latch high in cycles 65–66.
  - `o_done` high in cycle 67 only.
  - `o_busy` high in cycles 1–66.
- Same frame with `MSB_FIRST`=0 → sampled sequence 1100_0011_1010_0101.
- Data and start changes mid-frame: change `i_data` to 16'h0000 at cycle 10, and pulse `i_start` at cycle 20.
  - The shifted frame is still A5C3.
  - Exactly one `o_done`.
  - No second frame starts.
- Back-to-back frames: hold `i_start`=1 with `CLK_DIV`=1.
  - Frames repeat with a period of 34 cycles.
  - `o_done` and the next frame's capture occur in the same cycle.
- Reset mid-frame: assert `i_reset` asynchronously at cycle 30.
  - All outputs are 0 within that cycle.
  - No latch and no `o_done`.
  - After release, a new `i_start` produces a full, correct frame.
- Auto-refresh: with `SEG7_SER_AUTO_REFRESH_EN` defined and `REFRESH_CYCLES`=16, no `i_start`.
  - First frame starts 16 cycles after reset release.
  - Each next frame starts 16 IDLE cycles after each `o_done`.
  - An `i_start` pulse coinciding with expiry yields one frame.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state encoding and segment bit positions for the display path
package display_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_LATCH    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_SHIFT_LO = ST_SHIFT_LO,
    S_SHIFT_HI = ST_SHIFT_HI,
    S_LATCH    = ST_LATCH
  } state_t;

  // Bit position of each segment inside one SEG_WIDTH digit pattern
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

endpackage

// File: rtl/serial_tick_gen.sv
// rtl/serial_tick_gen.sv - loadable down-counter giving one tick every CLK_DIV enabled cycles
module serial_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= RELOAD;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/seg7_frame_serializer.sv
// rtl/seg7_frame_serializer.sv - shifts a packed 7-segment frame out on data/clock/latch lines
// Optional self-refresh when SEG7_SER_AUTO_REFRESH_EN is defined.
module seg7_frame_serializer #(
  parameter int NUM_DIGITS     = 6,
  parameter int SEG_WIDTH      = 8,
  parameter int CLK_DIV        = 4,
  parameter int MSB_FIRST      = 1,
  parameter int REFRESH_CYCLES = 1024
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [NUM_DIGITS*SEG_WIDTH-1:0] i_data,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_serial_data,
  output logic                            o_serial_clk,
  output logic                            o_serial_latch
);
  import display_pkg::*;

  localparam int B  = NUM_DIGITS * SEG_WIDTH;
  localparam int BW = $clog2(B + 1);

  state_t         r_state, w_state_next;
  logic [B-1:0]   r_shift, w_shift_next;
  logic [BW-1:0]  r_bits, w_bits_next;
  logic           r_busy, r_done, r_sdata, r_sclk, r_latch;
  logic           w_tick, w_go, w_done_next, w_bit;

`ifdef SEG7_SER_AUTO_REFRESH_EN
  localparam int IW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(REFRESH_CYCLES - 1);

  logic [IW-1:0] r_idle;
  logic          w_expire;

  // Counts IDLE cycles; any frame start (requested or automatic) restarts it
  assign w_expire = (r_state == S_IDLE) && (r_idle == IDLE_LAST);
  assign w_go     = i_start || w_expire;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idle <= '0;
    end else if ((r_state != S_IDLE) || w_go) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  logic w_unused_refresh;
  assign w_unused_refresh = (REFRESH_CYCLES != 0);
  assign w_go = i_start;
`endif

  serial_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_state_next != r_state),
    .i_en    (r_state != S_IDLE),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bits_next  = r_bits;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_next = S_SHIFT_LO;
          w_shift_next = i_data;
          w_bits_next  = BW'(B - 1);
        end
      end
      S_SHIFT_LO: begin
        if (w_tick) w_state_next = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (w_tick) begin
          if (r_bits == '0) begin
            w_state_next = S_LATCH;
          end else begin
            w_state_next = S_SHIFT_LO;
            w_bits_next  = r_bits - BW'(1);
            w_shift_next = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
          end
        end
      end
      S_LATCH: begin
        if (w_tick) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_bit = (MSB_FIRST != 0) ? w_shift_next[B-1] : w_shift_next[0];

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bits  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sdata <= 1'b0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_bits  <= w_bits_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_done_next;
      r_sdata <= ((w_state_next == S_SHIFT_LO) || (w_state_next == S_SHIFT_HI)) && w_bit;
      r_sclk  <= (w_state_next == S_SHIFT_HI);
      r_latch <= (w_state_next == S_LATCH);
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_serial_data  = r_sdata;
  assign o_serial_clk   = r_sclk;
  assign o_serial_latch = r_latch;

endmodule
